// File: rtl/vga_hvsync_generator.sv
// ============================================================================
// vga_hvsync_generator : free-running VGA raster timing (hpos/vpos counters,
//                        hsync/vsync, display_on). Optional: HVSYNC_PIXEL_CE_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_hvsync_generator #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
`ifdef HVSYNC_PIXEL_CE_EN
   input  logic       pixel_ce,
`endif
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] c_H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] c_H_DISP     = 10'(H_DISPLAY);
   localparam logic [9:0] c_V_DISP     = 10'(V_DISPLAY);
   localparam logic [9:0] c_HS_START   = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] c_HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] c_VS_START   = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] c_VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [9:0] hpos_q, hpos_d;
   logic [9:0] vpos_q, vpos_d;
   logic       w_adv;

`ifdef HVSYNC_PIXEL_CE_EN
   assign w_adv = pixel_ce;
`else
   assign w_adv = 1'b1;
`endif

   // Terminal-count wrap keeps both counters inside their totals at all times.
   always_comb begin
      hpos_d = hpos_q;
      vpos_d = vpos_q;
      if (w_adv) begin
         if (hpos_q == c_H_LAST) begin
            hpos_d = '0;
            vpos_d = (vpos_q == c_V_LAST) ? 10'd0 : vpos_q + 10'd1;
         end else begin
            hpos_d = hpos_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hpos_q <= '0;
         vpos_q <= '0;
      end else begin
         hpos_q <= hpos_d;
         vpos_q <= vpos_d;
      end
   end

   // Decodes are purely combinational so they line up with the counters exactly.
   assign hsync      = !((hpos_q >= c_HS_START) && (hpos_q < c_HS_END));
   assign vsync      = !((vpos_q >= c_VS_START) && (vpos_q < c_VS_END));
   assign display_on = (hpos_q < c_H_DISP) && (vpos_q < c_V_DISP) && !reset;
   assign hpos       = hpos_q;
   assign vpos       = vpos_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_hvsync_generator.sv
// ============================================================================
// tb_vga_hvsync_generator : directed self-checking bench for the VGA timing
//                           generator (full-size line plus a reduced-size frame)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_hvsync_generator;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
`ifdef HVSYNC_PIXEL_CE_EN
   logic       pixel_ce = 1'b1;
`endif
   logic       hsync, vsync, display_on;
   logic [9:0] hpos, vpos;
   logic       s_hsync, s_vsync, s_display_on;
   logic [9:0] s_hpos, s_vpos;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   vga_hvsync_generator u_dut (
      .clk        (clk),
      .reset      (reset),
`ifdef HVSYNC_PIXEL_CE_EN
      .pixel_ce   (pixel_ce),
`endif
      .hsync      (hsync),
      .vsync      (vsync),
      .display_on (display_on),
      .hpos       (hpos),
      .vpos       (vpos)
   );

   // Reduced timing: 16 x 13 total, 8 x 6 visible, so a whole frame is 208 clocks.
   vga_hvsync_generator #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) u_small (
      .clk        (clk),
      .reset      (reset),
`ifdef HVSYNC_PIXEL_CE_EN
      .pixel_ce   (pixel_ce),
`endif
      .hsync      (s_hsync),
      .vsync      (s_vsync),
      .display_on (s_display_on),
      .hpos       (s_hpos),
      .vpos       (s_vpos)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int hs_low;
      int de_low;
      int vs_low;
      int de_on;
      int shs_low;

      // Reset state
      tick();
      tick();
      check_val("rst_hpos", hpos, 0);
      check_val("rst_vpos", vpos, 0);
      check_val("rst_hsync", hsync, 1);
      check_val("rst_vsync", vsync, 1);
      check_val("rst_de", display_on, 0);

      // First full line after release
      reset  = 1'b0;
      hs_low = 0;
      de_low = 0;
      for (int i = 1; i <= 800; i++) begin
         tick();
         if (!hsync) hs_low++;
         if (!display_on) de_low++;
         case (i)
            1: begin
               check_val("first_hpos", hpos, 1);
               check_val("first_de", display_on, 1);
            end
            639: begin
               check_val("hpos_639", hpos, 639);
               check_val("de_h639", display_on, 1);
            end
            640: check_val("de_h640", display_on, 0);
            655: check_val("hs_h655", hsync, 1);
            656: check_val("hs_h656", hsync, 0);
            751: check_val("hs_h751", hsync, 0);
            752: check_val("hs_h752", hsync, 1);
            799: begin
               check_val("hpos_799", hpos, 799);
               check_val("vpos_799", vpos, 0);
            end
            800: begin
               check_val("wrap_hpos", hpos, 0);
               check_val("wrap_vpos", vpos, 1);
               check_val("wrap_de", display_on, 1);
            end
            default: ;
         endcase
      end
      check_val("hs_low_cnt", hs_low, 96);
      check_val("de_low_cnt", de_low, 160);

      // Asynchronous reset in the middle of line 1
      for (int i = 0; i < 300; i++) tick();
      check_val("mid_hpos", hpos, 300);
      #2 reset = 1'b1;
      #1;
      check_val("async_hpos", hpos, 0);
      check_val("async_vpos", vpos, 0);
      check_val("async_hsync", hsync, 1);
      check_val("async_vsync", vsync, 1);
      check_val("async_de", display_on, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check_val("rel_hpos", hpos, 1);
      check_val("rel_de", display_on, 1);

      // Whole frame on the reduced-size instance
      do_reset();
      vs_low  = 0;
      de_on   = 0;
      shs_low = 0;
      for (int i = 1; i <= 208; i++) begin
         tick();
         if (!s_vsync) vs_low++;
         if (s_display_on) de_on++;
         if (!s_hsync) shs_low++;
         case (i)
            7:   check_val("s_de_h7", s_display_on, 1);
            8:   check_val("s_de_h8", s_display_on, 0);
            80: begin
               check_val("s_vpos_5", s_vpos, 5);
               check_val("s_de_v5", s_display_on, 1);
            end
            96: begin
               check_val("s_vpos_6", s_vpos, 6);
               check_val("s_de_v6", s_display_on, 0);
            end
            127: check_val("s_vs_v7", s_vsync, 1);
            128: check_val("s_vs_v8", s_vsync, 0);
            159: check_val("s_vs_v9", s_vsync, 0);
            160: check_val("s_vs_v10", s_vsync, 1);
            207: begin
               check_val("s_last_hpos", s_hpos, 15);
               check_val("s_last_vpos", s_vpos, 12);
            end
            208: begin
               check_val("s_fwrap_hpos", s_hpos, 0);
               check_val("s_fwrap_vpos", s_vpos, 0);
            end
            default: ;
         endcase
      end
      check_val("s_vs_low_cnt", vs_low, 32);
      check_val("s_de_on_cnt", de_on, 48);
      check_val("s_hs_low_cnt", shs_low, 39);

`ifdef HVSYNC_PIXEL_CE_EN
      // Divided pixel strobe: one enable every four clocks
      pixel_ce = 1'b0;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         pixel_ce = (k % 4 == 0);
         tick();
         if (k == 3) check_val("ce_hpos_1", hpos, 1);
      end
      check_val("ce_hpos_4", hpos, 4);
      pixel_ce = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check_val("hold_hpos", hpos, 4);
      check_val("hold_vpos", vpos, 0);
      check_val("hold_hsync", hsync, 1);
      check_val("hold_vsync", vsync, 1);
      check_val("hold_de", display_on, 1);
      check_val("hold_s_hpos", s_hpos, 4);
      pixel_ce = 1'b1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
